id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// memory-hold freeze; also counts the load-use bubbles it inserts.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic            id_reg_write_enable,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_valid,
   input  logic [3:0]      id_alu_ctrl,
   input  logic            ex_branch_taken,
   input  logic            mem_hold,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write_enable,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_valid,
   output logic [3:0]      ex_alu_ctrl,
   output logic            stall_id,
   output logic [31:0]     stall_count
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write_enable;
      logic            mem_read;
      logic            mem_write;
      logic            valid;
      logic [3:0]      alu_ctrl;
   } ex_bank_t;

   localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

   ex_bank_t    ex_q, ex_d, id_bank_s;
   logic [31:0] stall_count_q, stall_count_d;
   logic        load_use_s;

   // Gather decode fields into the same layout as the execute bank.
   always_comb begin
      id_bank_s.pc               = id_pc;
      id_bank_s.rs1_data         = id_rs1_data;
      id_bank_s.rs2_data         = id_rs2_data;
      id_bank_s.imm              = id_imm;
      id_bank_s.rs1              = id_rs1;
      id_bank_s.rs2              = id_rs2;
      id_bank_s.rd               = id_rd;
      id_bank_s.reg_write_enable = id_reg_write_enable;
      id_bank_s.mem_read         = id_mem_read;
      id_bank_s.mem_write        = id_mem_write;
      id_bank_s.valid            = id_valid;
      id_bank_s.alu_ctrl         = id_alu_ctrl;
   end

   // A load in execute whose rd (never x0) is read by the decode instruction.
   always_comb begin
      load_use_s = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                   ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_q.rd)));
   end

   assign stall_id = mem_hold || (load_use_s && !ex_branch_taken);

   // Next-state priority: flush, then freeze, then load-use bubble, then capture.
   always_comb begin
      ex_d          = ex_q;
      stall_count_d = stall_count_q;
      if (ex_branch_taken) begin
         ex_d = '0;
      end else if (mem_hold) begin
         ex_d = ex_q;
      end else if (load_use_s) begin
         ex_d = '0;
         if (stall_count_q != COUNT_MAX) begin
            stall_count_d = stall_count_q + 32'd1;
         end else begin
            stall_count_d = stall_count_q;
         end
      end else if (id_valid) begin
         ex_d = id_bank_s;
      end else begin
         ex_d = '0;
      end
   end

   // Execute register bank and bubble counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q          <= '0;
         stall_count_q <= 32'd0;
      end else begin
         ex_q          <= ex_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign ex_pc               = ex_q.pc;
   assign ex_rs1_data         = ex_q.rs1_data;
   assign ex_rs2_data         = ex_q.rs2_data;
   assign ex_imm              = ex_q.imm;
   assign ex_rs1              = ex_q.rs1;
   assign ex_rs2              = ex_q.rs2;
   assign ex_rd               = ex_q.rd;
   assign ex_reg_write_enable = ex_q.reg_write_enable;
   assign ex_mem_read         = ex_q.mem_read;
   assign ex_mem_write        = ex_q.mem_write;
   assign ex_valid            = ex_q.valid;
   assign ex_alu_ctrl         = ex_q.alu_ctrl;
   assign stall_count         = stall_count_q;

endmodule
